// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int c_LEN_WIDTH      = 16;
    localparam int c_BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_CHECK  = 3'd3,
        ST_LOAD   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Stream is little-endian, memory words are big-endian: mirror the lane.
    function automatic logic [c_LEN_WIDTH-1:0] swap_byte_addr(input logic [c_LEN_WIDTH-1:0] n);
        return {n[c_LEN_WIDTH-1:2], ~n[1:0]};
    endfunction

    function automatic logic holds_core(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_CHECK) ||
               (s == ST_LOAD)   || (s == ST_ERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time byte-stream loader for the instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = 32,
    parameter int IMEM_WIDTH      = 8,
    parameter int IMEM_DEPTH      = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       wr_en,
    output logic [IMEM_ADDR_WIDTH-1:0] wr_addr,
    output logic [IMEM_WIDTH-1:0]      wr_data,
    output logic                       cpu_hold,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam logic [c_LEN_WIDTH:0]   c_DEPTH     = (c_LEN_WIDTH+1)'(IMEM_DEPTH);
    localparam logic [c_LEN_WIDTH-1:0] c_WORD_MASK = c_LEN_WIDTH'(c_BYTES_PER_WORD - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_LEN_WIDTH-1:0]  r_len;
    logic [c_LEN_WIDTH-1:0]  r_byte_cnt;
    logic                    w_xfer;
    logic                    w_start_ok;
    logic                    w_len_bad;
    logic                    w_last_byte;

    assign w_xfer      = s_valid & s_ready;
    assign w_start_ok  = start & ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_len_bad   = ((r_len & c_WORD_MASK) != '0) || ({1'b0, r_len} > c_DEPTH);
    assign w_last_byte = (r_byte_cnt == (r_len - c_LEN_WIDTH'(1)));

    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) w_state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                s_ready = 1'b1;
                if (s_valid) w_state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                s_ready = 1'b1;
                if (s_valid) w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (r_len == '0)    w_state_next = ST_DONE;
                else if (w_len_bad) w_state_next = ST_ERR;
                else                w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid && w_last_byte) w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_byte_cnt <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            wr_en    <= 1'b0;
            cpu_hold <= holds_core(w_state_next);
            busy     <= holds_core(w_state_next);
            done     <= (w_state_next == ST_DONE) && (r_state != ST_DONE);
            error    <= (w_state_next == ST_ERR);

            if (w_start_ok) begin
                r_len      <= '0;
                r_byte_cnt <= '0;
            end

            if (w_xfer) begin
                case (r_state)
                    ST_LEN_LO: r_len[7:0]  <= s_data;
                    ST_LEN_HI: r_len[15:8] <= s_data;
                    ST_LOAD: begin
                        wr_en      <= 1'b1;
                        wr_addr    <= IMEM_ADDR_WIDTH'(swap_byte_addr(r_byte_cnt));
                        wr_data    <= IMEM_WIDTH'(s_data);
                        r_byte_cnt <= r_byte_cnt + c_LEN_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
